// File: rtl/sigma_delta_tx.sv
// Sigma-delta PCM to 1-bit transmitter: 1-entry sample buffer, IDLE/RUN sequencer, oversampling modulator.
// Define SIGMA_DELTA_SECOND_ORDER_EN for the saturating second-order loop; default build is first-order.
module sigma_delta_tx #(
   parameter int DATA_W = 16,
   parameter int OSR_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              sample_valid,
   output logic              sample_ready,
   input  logic [OSR_W-1:0]  osr,
   output logic              bit_out,
   output logic              bit_strobe,
   output logic              underrun,
   output logic              state_dbg
);

   // Handshake: a sample transfers on a rising edge where sample_valid && sample_ready;
   // sample_ready is purely registered (buffer empty) and never depends on sample_valid.

`ifdef SIGMA_DELTA_SECOND_ORDER_EN
   localparam int ACC_W = DATA_W + 4;
`else
   localparam int ACC_W = DATA_W + 2;
`endif

   localparam logic signed [ACC_W-1:0] FB_MAG =
      {{(ACC_W-DATA_W){1'b0}}, 1'b1, {(DATA_W-1){1'b0}}};

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t                   state_q, state_d;
   logic [DATA_W-1:0]        buf_q, buf_d;
   logic                     buf_full_q, buf_full_d;
   logic [DATA_W-1:0]        act_q, act_d;
   logic [OSR_W-1:0]         cnt_q, cnt_d;
   logic                     bit_q, bit_d;
   logic                     strobe_q, strobe_d;
   logic                     underrun_q, underrun_d;
   logic signed [ACC_W-1:0]  acc1_q, acc1_d;

   logic signed [ACC_W-1:0]  x_ext;
   logic signed [ACC_W-1:0]  fb;
   logic signed [ACC_W-1:0]  acc1_next;
   logic                     mod_bit;
   logic                     accept;
   logic                     period_end;
   logic                     load;
   logic [OSR_W-1:0]         cnt_reload;

`ifdef SIGMA_DELTA_SECOND_ORDER_EN
   localparam logic signed [ACC_W+1:0] SAT_MAX_W = {3'b000, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W+1:0] SAT_MIN_W = {3'b111, {(ACC_W-1){1'b0}}};

   logic signed [ACC_W-1:0]  acc2_q, acc2_d;
   logic signed [ACC_W+1:0]  acc1_wide;
   logic signed [ACC_W+1:0]  acc2_wide;
   logic signed [ACC_W-1:0]  acc2_next;

   // Sums are formed two bits wider than the accumulators, then clamped.
   function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W+1:0] v);
      logic signed [ACC_W-1:0] r;
      if (v > SAT_MAX_W) begin
         r = {1'b0, {(ACC_W-1){1'b1}}};
      end else if (v < SAT_MIN_W) begin
         r = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
         r = v[ACC_W-1:0];
      end
      return r;
   endfunction
`endif

   assign sample_ready = ~buf_full_q;
   assign bit_out      = bit_q;
   assign bit_strobe   = strobe_q;
   assign underrun     = underrun_q;
   assign state_dbg    = state_q;

   always_comb begin
      x_ext = {{(ACC_W-DATA_W){act_q[DATA_W-1]}}, act_q};
      fb    = bit_q ? FB_MAG : -FB_MAG;
`ifdef SIGMA_DELTA_SECOND_ORDER_EN
      acc1_wide = {{2{acc1_q[ACC_W-1]}}, acc1_q}
                + {{2{x_ext[ACC_W-1]}}, x_ext}
                - {{2{fb[ACC_W-1]}}, fb};
      acc1_next = sat_acc(acc1_wide);
      acc2_wide = {{2{acc2_q[ACC_W-1]}}, acc2_q}
                + {{2{acc1_next[ACC_W-1]}}, acc1_next}
                - {{2{fb[ACC_W-1]}}, fb};
      acc2_next = sat_acc(acc2_wide);
      mod_bit   = ~acc2_next[ACC_W-1];
`else
      // x - fb stays within +/-2^DATA_W, so DATA_W+2 bits cannot wrap.
      acc1_next = acc1_q + x_ext - fb;
      mod_bit   = ~acc1_next[ACC_W-1];
`endif
   end

   always_comb begin
      accept     = sample_valid && !buf_full_q;
      period_end = (state_q == RUN) && (cnt_q == '0);
      load       = buf_full_q && ((state_q == IDLE) || period_end);
      // osr is a bit count per sample; zero behaves as a period of one cycle.
      cnt_reload = (osr == '0) ? '0 : osr - 1'b1;

      state_d    = state_q;
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      act_d      = act_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      strobe_d   = 1'b0;
      underrun_d = 1'b0;
      acc1_d     = acc1_q;
`ifdef SIGMA_DELTA_SECOND_ORDER_EN
      acc2_d     = acc2_q;
`endif

      if (load) begin
         act_d      = buf_q;
         buf_full_d = 1'b0;
      end
      // Applied after the load so a same-edge accept leaves the buffer full.
      if (accept) begin
         buf_d      = sample_in;
         buf_full_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            bit_d = 1'b0;
            if (load) begin
               state_d = RUN;
               cnt_d   = cnt_reload;
            end
         end
         RUN: begin
            strobe_d = 1'b1;
            bit_d    = mod_bit;
            acc1_d   = acc1_next;
`ifdef SIGMA_DELTA_SECOND_ORDER_EN
            acc2_d   = acc2_next;
`endif
            if (period_end) begin
               cnt_d = cnt_reload;
               if (!buf_full_q) begin
                  underrun_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         buf_q      <= '0;
         buf_full_q <= 1'b0;
         act_q      <= '0;
         cnt_q      <= '0;
         bit_q      <= 1'b0;
         strobe_q   <= 1'b0;
         underrun_q <= 1'b0;
         acc1_q     <= '0;
`ifdef SIGMA_DELTA_SECOND_ORDER_EN
         acc2_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         buf_q      <= buf_d;
         buf_full_q <= buf_full_d;
         act_q      <= act_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         strobe_q   <= strobe_d;
         underrun_q <= underrun_d;
         acc1_q     <= acc1_d;
`ifdef SIGMA_DELTA_SECOND_ORDER_EN
         acc2_q     <= acc2_d;
`endif
      end
   end

endmodule

// File: tb/tb_sigma_delta_tx.sv
// Bench for sigma_delta_tx: bit-stream scoreboard, latency, underrun, handshake, reset and density checks.
module tb_sigma_delta_tx;
   localparam int DATA_W = 16;
   localparam int OSR_W  = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [DATA_W-1:0] sample_in = '0;
   logic              sample_valid = 1'b0;
   logic              sample_ready;
   logic [OSR_W-1:0]  osr = 8'd8;
   logic              bit_out;
   logic              bit_strobe;
   logic              underrun;
   logic              state_dbg;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [0:0] exp_q[$];
   bit         sb_en = 1'b0;

   sigma_delta_tx #(.DATA_W(DATA_W), .OSR_W(OSR_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .osr          (osr),
      .bit_out      (bit_out),
      .bit_strobe   (bit_strobe),
      .underrun     (underrun),
      .state_dbg    (state_dbg)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (sb_en && bit_strobe && exp_q.size() > 0) begin
         logic [0:0] e;
         e = exp_q.pop_front();
         tests_run++;
         if (bit_out !== e[0]) begin
            tests_failed++;
            $display("FAIL sb_bit: got %0b expected %0b at %0t", bit_out, e[0], $time);
         end
      end
   end

   // ---------------- check helpers ----------------
   task automatic check_eq(input string name, input int act, input int exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_rng(input string name, input int act, input int lo, input int hi);
      tests_run++;
      if (act < lo || act > hi) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Holds reset, checks reset values, releases on a falling edge.
   task automatic do_reset();
      sample_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      check_eq("rst_ready",    sample_ready, 1);
      check_eq("rst_bit",      bit_out,      0);
      check_eq("rst_strobe",   bit_strobe,   0);
      check_eq("rst_underrun", underrun,     0);
      check_eq("rst_state",    state_dbg,    0);
      tick();
      tick();
      @(negedge clk);
      rst = 1'b1;
   endtask

   // First-order bits for a zero input from reset: 1,1,0,1,0,1,...
   task automatic push_zero_pattern(input int n);
`ifndef SIGMA_DELTA_SECOND_ORDER_EN
      for (int i = 0; i < n; i++) begin
         if (i < 2) exp_q.push_back(1'b1);
         else       exp_q.push_back((i % 2 == 0) ? 1'b0 : 1'b1);
      end
`endif
   endtask

   // Offers one sample, then checks strobe latency: low after edges 0 and 1, high after edge 2.
   task automatic send_sample(input logic [DATA_W-1:0] x);
      int guard;
      guard = 0;
      while (!sample_ready && guard < 100) begin
         tick();
         guard++;
      end
      if (guard >= 100) begin
         check_eq("send_ready_timeout", guard, 0);
      end
      sample_in    = x;
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      check_eq("lat_e0_strobe", bit_strobe, 0);
      tick();
      check_eq("lat_e1_strobe", bit_strobe, 0);
      check_eq("lat_e1_state",  state_dbg,  1);
      tick();
      check_eq("lat_e2_strobe", bit_strobe, 1);
   endtask

   task automatic count_bits(input int n, output int ones, output int urs);
      int strobes;
      int cyc;
      ones    = 0;
      urs     = 0;
      strobes = 0;
      cyc     = 0;
      while (strobes < n && cyc < n + 100) begin
         @(negedge clk);
         cyc++;
         if (bit_strobe) begin
            strobes++;
            if (bit_out) ones++;
         end
         if (underrun) urs++;
      end
      check_eq("count_strobes", strobes, n);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int ones;
      int urs;
      int g;
      int acc_cnt;
      int rdy_low;
      int strb;

      // A: zero input, osr=8, buffer kept fed
      do_reset();
      osr = 8'd8;
      exp_q.delete();
      push_zero_pattern(16);
      sb_en = 1'b1;
      send_sample(16'h0000);
      sample_in    = 16'h0000;
      sample_valid = 1'b1;
      strb = 0;
      urs  = 0;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (bit_strobe) strb++;
         if (underrun)   urs++;
      end
      check_eq("a_strobe_every_cycle", strb, 24);
      check_eq("a_no_underrun", urs, 0);
      sb_en = 1'b0;
      check_eq("a_sb_drained", exp_q.size(), 0);
      sample_valid = 1'b0;

      // B: 0x4000 at osr=255 for four periods -> 765 +/- 2 ones
      do_reset();
      osr = 8'd255;
      send_sample(16'h4000);
      sample_in    = 16'h4000;
      sample_valid = 1'b1;
      count_bits(1020, ones, urs);
      check_rng("b_density_0x4000", ones, 763, 767);
      check_eq("b_no_underrun", urs, 0);
      sample_valid = 1'b0;

      // C: osr=4, single sample, osr raised to 8 mid-period
      do_reset();
      osr = 8'd4;
      exp_q.delete();
      push_zero_pattern(16);
      sb_en = 1'b1;
      send_sample(16'h0000);
      g = 0;
      do begin
         @(negedge clk);
         g++;
      end while (!underrun && g < 40);
      check_eq("c_first_underrun", g, 4);
      for (int k = 0; k < 3; k++) begin
         g = 0;
         do begin
            @(negedge clk);
            g++;
            if (k == 0 && g == 2) osr = 8'd8;
         end while (!underrun && g < 40);
         check_eq($sformatf("c_underrun_gap%0d", k), g, (k == 0) ? 4 : 8);
      end
      check_eq("c_strobe_continues", bit_strobe, 1);
      sb_en = 1'b0;
      check_eq("c_sb_drained", exp_q.size(), 0);

      // D: sample_valid held high, osr=4 -> one accept per period
      do_reset();
      osr = 8'd4;
      send_sample(16'h0000);
      sample_in    = 16'h0000;
      sample_valid = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      acc_cnt = 0;
      rdy_low = 0;
      urs     = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (sample_ready && sample_valid) acc_cnt++;
         if (!sample_ready) rdy_low++;
         if (underrun) urs++;
      end
      check_eq("d_accepts", acc_cnt, 10);
      check_eq("d_ready_low_cycles", rdy_low, 30);
      check_eq("d_no_underrun", urs, 0);

      // E: asynchronous reset mid-period with the buffer full
      g = 0;
      do begin
         @(negedge clk);
         g++;
      end while (!(sample_ready == 1'b0 && bit_out == 1'b1) && g < 40);
      check_rng("e_found_full_buffer", g, 1, 39);
      #2 rst = 1'b0;
      #1;
      check_eq("e_async_ready",    sample_ready, 1);
      check_eq("e_async_bit",      bit_out,      0);
      check_eq("e_async_strobe",   bit_strobe,   0);
      check_eq("e_async_underrun", underrun,     0);
      check_eq("e_async_state",    state_dbg,    0);
      sample_valid = 1'b0;
      tick();
      @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      push_zero_pattern(12);
      sb_en = 1'b1;
      send_sample(16'h0000);
      for (int i = 0; i < 16; i++) @(negedge clk);
      sb_en = 1'b0;
      check_eq("e_sb_drained", exp_q.size(), 0);

      // F: full-scale inputs
      do_reset();
      osr = 8'd255;
      send_sample(16'h7FFF);
      sample_in    = 16'h7FFF;
      sample_valid = 1'b1;
      count_bits(510, ones, urs);
      check_rng("f_density_max", ones, 508, 510);
      sample_valid = 1'b0;

      do_reset();
      osr = 8'd255;
      send_sample(16'h8000);
      sample_in    = 16'h8000;
      sample_valid = 1'b1;
      count_bits(510, ones, urs);
      check_rng("f_density_min", ones, 0, 2);
      sample_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/sigma_delta_tx.md
SIGMA_DELTA_TX -- requirements
Module: sigma_delta_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 16: signed sample width, valid range 8..24.
REQ-002 SHALL have parameter OSR_W, default 8: width of oversampling-ratio input.
REQ-003 SHALL have port clk  input  1: sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port sample_in  input  DATA_W: two's-complement PCM sample.
REQ-006 SHALL have port sample_valid  input  1: sample_in valid.
REQ-007 SHALL have port sample_ready  output  1: block can accept a sample.
REQ-008 SHALL have port osr  input  OSR_W: output bits per sample, sampled at each period start.
REQ-009 SHALL have port bit_out  output  1: registered 1-bit modulated stream, suitable for the FIR x_in.
REQ-010 SHALL have port bit_strobe  output  1: high in every cycle bit_out carries a new bit.
REQ-011 SHALL have port underrun  output  1: one-cycle pulse, period ended with no buffered sample.

Function
REQ-012 SHALL hold a 1-entry input buffer; sample_ready = buffer empty (registered state only, no combinational path from sample_valid).
REQ-013 SHALL accept a sample on a rising edge where sample_valid && sample_ready; buffer then full.
REQ-014 SHALL implement states IDLE and RUN; IDLE -> RUN on the edge that moves a full buffer into the active-sample register; RUN never returns to IDLE except via reset.
REQ-015 In IDLE, bit_out = 0 and bit_strobe = 0.
REQ-016 In RUN, SHALL update the modulator on every edge; first bit_strobe high 2 cycles after the accept edge.
REQ-017 SHALL latch osr at each period start; osr = 0 treated as 1; period length = latched osr cycles.
REQ-018 On the last cycle of a period: buffer full -> load buffer into active register, buffer empty same edge; buffer empty -> reuse current active sample, pulse underrun one cycle.
REQ-019 Accept and load on the same edge SHALL both occur; buffer ends full with the new sample, no sample lost.
REQ-020 First-order loop: fb = bit_out ? +2^(DATA_W-1) : -2^(DATA_W-1); acc1 <= acc1 + x - fb; bit_out <= (acc1_next >= 0); acc1 width DATA_W+2, no overflow for any input.
REQ-021 For constant input x, ones density over N*osr bits SHALL equal (x + 2^(DATA_W-1)) / 2^DATA_W within 2/(N*osr).
REQ-022 osr change mid-period SHALL take effect only at the next period start.

Reset
REQ-023 On rst low, immediately: state IDLE, buffer empty, sample_ready 1, bit_out 0, bit_strobe 0, underrun 0, all accumulators and counters 0.
REQ-024 Reset asserted mid-period SHALL discard active and buffered samples; after release the block behaves as from power-up.
REQ-025 First edge after rst release SHALL be able to accept a sample.

Configuration
REQ-026 Macro SIGMA_DELTA_SECOND_ORDER_EN defined: second-order loop, acc1 <= acc1 + x - fb; acc2 <= acc2 + acc1_next - fb; bit_out <= (acc2_next >= 0); accumulators DATA_W+4 bits, saturating at their extremes.
REQ-027 Macro undefined: first-order loop of REQ-020 only, no acc2 logic; interface and timing identical in both builds.

Verification
REQ-028 Reset, sample 0x0000, osr=8, keep buffer fed -> after settling bit_out alternates 1,0 (density 50%), bit_strobe every cycle.
REQ-029 Sample 0x4000 (DATA_W=16), osr=255, 4 periods -> ones count 765 +/-2 of 1020 bits.
REQ-030 osr=4, one sample then no more -> underrun pulses every 4 cycles, bit stream continues with last sample.
REQ-031 Hold sample_valid high continuously, osr=4 -> sample_ready low exactly while buffer full, one acceptance per period, no sample dropped or duplicated.
REQ-032 Assert rst mid-period with buffer full -> all outputs at reset values same cycle (asynchronous), sample_ready 1, next sample restarts with first strobe 2 cycles after accept.
REQ-033 Sample 0x7FFF and 0x8000, osr=255, both builds -> densities ~100% / ~0% with no accumulator wrap (bit_out never flips polarity pattern).
